// File: rtl/icache_pkg.sv
// Shared types and geometry for the instruction-side line provider.
// Line geometry is fixed at four 32-bit words; only the line count is tunable.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REQ,
    WAIT,
    DRAIN
  } state_e;

  localparam int LINE_WIDTH     = 128;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_BITS    = 4;

  // A two-line store still needs one index bit, which $clog2(2) already gives;
  // the clamp keeps a degenerate count from producing a zero-width index.
  function automatic int index_width(input int num_lines);
    return (num_lines <= 2) ? 1 : $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_line_ctrl_if.sv
// Fetch-side line request plus word-serial instruction memory port.
// master = fetch queue / memory model side, slave = the line provider.
interface icache_line_ctrl_if
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] pc_in;
  logic                  rd_en;
  logic                  abort;
  logic [LINE_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  busy;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;

  modport master (
    output pc_in, rd_en, abort, mem_rvalid, mem_rdata,
    input  dout, dout_valid, busy, mem_req, mem_addr
  );

  modport slave (
    input  pc_in, rd_en, abort, mem_rvalid, mem_rdata,
    output dout, dout_valid, busy, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_array.sv
// Direct-mapped line store: combinational read, synchronous write.
// Only the valid bits are reset; tag and data are qualified by them.
module icache_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [LINE_WIDTH-1:0] rd_line_o,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [LINE_WIDTH-1:0] wr_line_i
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [LINE_WIDTH-1:0] data_q [NUM_LINES];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays deliberately have no reset so they map onto plain
  // RAM; a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge i_clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_line_ctrl.sv
// Line provider for the fetch queue: lookup, word-serial refill, abort handling.
// All interface outputs are registered; the FSM lives in one clocked block.
module icache_line_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = 8,
  parameter int ADDR_WIDTH = 32
) (
  input logic               i_clk,
  input logic               i_rst_n,
  icache_line_ctrl_if.slave bus
);

  localparam int IDX_W  = index_width(NUM_LINES);
  localparam int BASE_W = ADDR_WIDTH - OFFSET_BITS;
  localparam int TAG_W  = BASE_W - IDX_W;
  localparam int WORD_W = LINE_WIDTH / WORDS_PER_LINE;

  state_e                                  state_q;
  logic [1:0]                              cnt_q;
  logic [1:0]                              cnt_d;
  logic [BASE_W-1:0]                       line_base_q;
  logic [WORDS_PER_LINE-2:0][WORD_W-1:0]   fill_q;
  logic [LINE_WIDTH-1:0]                   dout_q;
  logic                                    dout_valid_q;
  logic                                    busy_q;
  logic                                    mem_req_q;
  logic [ADDR_WIDTH-1:0]                   mem_addr_q;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_WIDTH-1:0] rd_line;
  logic                  hit;
  logic                  fill_we;
  logic [LINE_WIDTH-1:0] fill_line;
  logic                  unused_offset;

  assign idx       = line_base_q[IDX_W-1:0];
  assign tag       = line_base_q[BASE_W-1:IDX_W];
  assign cnt_d     = cnt_q + 2'd1;
  assign hit       = rd_valid && (rd_tag == tag);
  assign fill_line = {bus.mem_rdata, fill_q};
  // The last word installs the line even when an abort arrives with it.
  assign fill_we   = (state_q == WAIT) && bus.mem_rvalid && (cnt_q == 2'd3);

  assign unused_offset = ^bus.pc_in[OFFSET_BITS-1:0];

  icache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .rd_idx_i   (idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .we_i       (fill_we),
    .wr_idx_i   (idx),
    .wr_tag_i   (tag),
    .wr_line_i  (fill_line)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      line_base_q  <= '0;
      fill_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      dout_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rd_en && !bus.abort) begin
            line_base_q <= bus.pc_in[ADDR_WIDTH-1:OFFSET_BITS];
            state_q     <= LOOKUP;
            busy_q      <= 1'b1;
          end
        end
        LOOKUP: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (hit) begin
            dout_q       <= rd_line;
            dout_valid_q <= 1'b1;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
          end else begin
            cnt_q      <= 2'd0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {line_base_q, 2'd0, 2'b00};
            state_q    <= REQ;
          end
        end
        // The request pulse is already on the bus; an abort here must drain it.
        REQ: state_q <= bus.abort ? DRAIN : WAIT;
        WAIT: begin
          if (bus.mem_rvalid) begin
            if (bus.abort) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (cnt_q == 2'd3) begin
              dout_q       <= fill_line;
              dout_valid_q <= 1'b1;
              state_q      <= IDLE;
              busy_q       <= 1'b0;
            end else begin
              fill_q[cnt_q] <= bus.mem_rdata;
              cnt_q         <= cnt_d;
              mem_req_q     <= 1'b1;
              mem_addr_q    <= {line_base_q, cnt_d, 2'b00};
              state_q       <= REQ;
            end
          end else if (bus.abort) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.mem_rvalid) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;

endmodule
